regbank_write_demux: RTL and testbench

- Write-side counterpart of the read-select mux trees in the single-cycle CPU datapath.
- A binary write address is decoded into a one-hot enable (decoder/demux tree). That enable steers wr_data into one of NUM_REGS storage registers.
- All register contents are exported flat, so the existing mux trees perform reads.
- A per-register dirty bitmap tracks registers written since the last clear; debug and verification use it.

---
 rtl/regbank_pkg.sv | 9 +
 rtl/regbank_write_demux_decoder_n.sv | 22 ++
 rtl/regbank_write_demux.sv | 33 +++
 tb/tb_regbank_write_demux.sv | 120 ++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared sizes and word/address types for the register bank write side
package regbank_pkg;
  localparam int WIDTH = 64;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int ZERO_REG = 31;
  typedef logic [WIDTH-1:0] reg_word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regbank_write_demux_decoder_n.sv
// decoder_n: enable-gated AW-to-2**AW one-hot decoder built recursively from 1-to-2 stages
module decoder_n #(
  parameter int AW = 5
) (
  input  logic            en,
  input  logic [AW-1:0]   a,
  output logic [2**AW-1:0] y
);
  generate
    if (AW == 1) begin : g_leaf
      assign y = {en & a[0], en & ~a[0]};
    end else begin : g_node
      logic en_lo, en_hi;
      logic [2**(AW-1)-1:0] y_lo, y_hi;
      assign en_hi = en & a[AW-1];
      assign en_lo = en & ~a[AW-1];
      decoder_n #(.AW(AW-1)) u_lo (.en(en_lo), .a(a[AW-2:0]), .y(y_lo));
      decoder_n #(.AW(AW-1)) u_hi (.en(en_hi), .a(a[AW-2:0]), .y(y_hi));
      assign y = {y_hi, y_lo};
    end
  endgenerate
endmodule

// File: rtl/regbank_write_demux.sv
// regbank_write_demux: decoded-write register bank with flat read export, dirty bitmap and saturating write count
module regbank_write_demux
  import regbank_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               wr_en,
  input  reg_addr_t                          wr_addr,
  input  reg_word_t                          wr_data,
  input  logic                               clr_dirty,
  output logic [NUM_REGS-1:0][WIDTH-1:0]     regs,
  output logic [NUM_REGS-1:0]                wr_onehot,
  output logic [NUM_REGS-1:0]                dirty,
  output logic [15:0]                        wr_count
);
  localparam logic [NUM_REGS-1:0] ZMASK = NUM_REGS'(1) << ZERO_REG;
  logic [NUM_REGS-1:0] dec, acc;
  decoder_n #(.AW(ADDR_W)) u_dec (.en(wr_en), .a(wr_addr), .y(dec));
  assign acc = dec & ~ZMASK;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      regs <= '0;
      wr_onehot <= '0;
      dirty <= '0;
      wr_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (acc[i]) regs[i] <= wr_data;
      wr_onehot <= dec;
      dirty <= clr_dirty ? acc : (dirty | acc);
      wr_count <= wr_count + 16'((|acc) && (wr_count != 16'hFFFF));
    end
endmodule

// File: tb/tb_regbank_write_demux.sv
// tb_regbank_write_demux: scoreboard bench for regbank_write_demux against a behavioural register-file model
module tb_regbank_write_demux;
  import regbank_pkg::*;
  logic clk = 0, reset_n = 0, wr_en = 0, clr_dirty = 0;
  reg_addr_t wr_addr = '0;
  reg_word_t wr_data = '0;
  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [NUM_REGS-1:0] wr_onehot, dirty;
  logic [15:0] wr_count;
  int errors = 0, checks = 0;
  typedef struct {
    reg_word_t r[NUM_REGS];
    logic [NUM_REGS-1:0] oh, d;
    logic [15:0] c;
  } exp_t;
  exp_t q[$];
  exp_t me;
  reg_word_t mem[NUM_REGS];
  logic [NUM_REGS-1:0] m_oh, m_d;
  int m_c;
  always #5 clk = ~clk;
  regbank_write_demux dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_dirty(clr_dirty), .regs(regs), .wr_onehot(wr_onehot), .dirty(dirty), .wr_count(wr_count)
  );
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic void model_reset();
    foreach (mem[i]) mem[i] = '0;
    m_oh = '0;
    m_d = '0;
    m_c = 0;
  endfunction
  task automatic check_zero(string tag);
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("%s regs[%0d]", tag, i), regs[i], 64'd0);
    chk({tag, " wr_onehot"}, 64'(wr_onehot), 64'd0);
    chk({tag, " dirty"}, 64'(dirty), 64'd0);
    chk({tag, " wr_count"}, 64'(wr_count), 64'd0);
  endtask
  task automatic step(bit en, int addr, reg_word_t data, bit clr);
    exp_t e;
    bit acc;
    @(negedge clk);
    wr_en = en;
    wr_addr = reg_addr_t'(addr);
    wr_data = data;
    clr_dirty = clr;
    @(posedge clk);
    acc = en && addr != ZERO_REG;
    if (acc) begin
      mem[addr] = data;
      if (m_c < 65535) m_c++;
    end
    m_oh = en ? (32'd1 << addr) : '0;
    if (clr) m_d = acc ? (32'd1 << addr) : '0;
    else if (acc) m_d[addr] = 1'b1;
    e.r = mem;
    e.oh = m_oh;
    e.d = m_d;
    e.c = 16'(m_c);
    q.push_back(e);
  endtask
  always begin
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      me = q.pop_front();
      for (int i = 0; i < NUM_REGS; i++) chk($sformatf("regs[%0d]", i), regs[i], me.r[i]);
      chk("wr_onehot", 64'(wr_onehot), 64'(me.oh));
      chk("dirty", 64'(dirty), 64'(me.d));
      chk("wr_count", 64'(wr_count), 64'(me.c));
      chk("onehot_shape", 64'($countones(wr_onehot) <= 1), 64'd1);
    end
  end
  initial begin
    model_reset();
    wr_en = 1;
    wr_addr = 3;
    wr_data = 64'hDEAD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("in_reset");
    reset_n = 1;
    wr_en = 0;
    repeat (2) step(0, 3, 64'hDEAD, 0);
    step(1, 5, 64'h0123_4567_89AB_CDEF, 0);
    step(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    step(0, 0, 64'd0, 0);
    for (int i = 0; i < 31; i++) step(1, i, 64'(i + 1), 0);
    step(1, 2, 64'd7, 0);
    step(1, 2, 64'd9, 0);
    step(1, 4, 64'h55, 1);
    step(0, 0, 64'd0, 1);
    step(1, 10, 64'hABCD, 0);
    @(negedge clk);
    wr_en = 1;
    wr_addr = 6;
    wr_data = 64'h6666;
    #2 reset_n = 0;
    #1 check_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    wr_en = 0;
    model_reset();
    step(0, 6, 64'd0, 0);
    for (int k = 0; k < 300; k++)
      step($urandom_range(3, 0) != 0, int'($urandom_range(NUM_REGS - 1, 0)), {$urandom, $urandom}, $urandom_range(7, 0) == 0);
    step(0, 0, 64'd0, 0);
    repeat (3) @(posedge clk);
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
